// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline front end.
//   NOP_INSTR         encoding inserted into a squashed IF/ID slot (sll $0,$0,0)
//   OP_J / OP_BEQ     primary opcodes referenced by the front end / decode
//   *_MSB / *_LSB     instruction field boundaries (opcode, funct, jump index)
//   fetch_state_t     fetch control FSM states
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int JIDX_MSB  = 25;
   localparam int JIDX_LSB  = 0;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register (instruction, PC+4, valid).
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   en          load enable; when low every field holds (stall)
//   clr         synchronous clear to a NOP bubble, only honoured when en=1
//   d_instr, d_pcplus4, d_valid   next contents
//   instr, pcplus4, valid         registered contents
module if_id_reg
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [31:0]      d_instr,
   input  logic [WIDTH-1:0] d_pcplus4,
   input  logic             d_valid,
   output logic [31:0]      instr,
   output logic [WIDTH-1:0] pcplus4,
   output logic             valid
);

   // Hold wins over clear: a stalled slot keeps its contents even if a
   // flush is requested in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr   <= NOP_INSTR;
         pcplus4 <= '0;
         valid   <= 1'b0;
      end else if (en) begin
         if (clr) begin
            instr   <= NOP_INSTR;
            pcplus4 <= '0;
            valid   <= 1'b0;
         end else begin
            instr   <= d_instr;
            pcplus4 <= d_pcplus4;
            valid   <= d_valid;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns pcF, drives the
// instruction memory address and captures the returned word into IF/ID.
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   stallF / stallD      hold PC / hold IF/ID this cycle
//   flushD               squash IF/ID (bubble)
//   pcsrcD, pcbranchD    taken branch and its target, resolved in decode
//   jumpD                jump resolved in decode (target from instrD)
//   imem_addr            registered pcF; imem_rdata is its combinational read
//   instrD, pcplus4D     IF/ID contents; opD/functD are slices of instrD
//   validD               instrD holds a real fetched instruction
//   fetch_cnt, flush_cnt performance counters, present only when the
//                        FETCH_PERF_CNT_EN macro is defined
module fetch_stage
   import mips_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stallF,
   input  logic             stallD,
   input  logic             flushD,
   input  logic             pcsrcD,
   input  logic             jumpD,
   input  logic [WIDTH-1:0] pcbranchD,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instrD,
   output logic [WIDTH-1:0] pcplus4D,
   output logic [5:0]       opD,
   output logic [5:0]       functD,
   output logic             validD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      fetch_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   fetch_state_t     state;
   logic [WIDTH-1:0] pcF;
   logic [WIDTH-1:0] pcplus4F;
   logic [WIDTH-1:0] pc_next;
   logic             ifid_en;
   logic             ifid_clr;
   logic             valid_r;
   logic             in_run;

   assign in_run   = (state == RUN);
   assign pcplus4F = pcF + WIDTH'(4);   // wraps modulo 2^WIDTH

   // Next PC: stall > jump > branch > sequential. During BOOT nothing
   // upstream is valid yet, so the PC simply advances.
   always_comb begin
      pc_next = pcplus4F;
      if (in_run) begin
         if (stallF)
            pc_next = pcF;
         else if (jumpD)
            pc_next = {pcplus4D[31:28], instrD[JIDX_MSB:JIDX_LSB], 2'b00};
         else if (pcsrcD)
            pc_next = pcbranchD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcF   <= RESET_PC;
         state <= BOOT;
      end else begin
         pcF   <= pc_next;
         state <= RUN;
      end
   end

   // BOOT ignores stall/flush: the first edge after reset is always a load.
   assign ifid_en  = !in_run || !stallD;
   assign ifid_clr = in_run && flushD;

   if_id_reg #(.WIDTH(WIDTH)) u_if_id (
      .clk       (clk),
      .reset     (reset),
      .en        (ifid_en),
      .clr       (ifid_clr),
      .d_instr   (imem_rdata),
      .d_pcplus4 (pcplus4F),
      .d_valid   (1'b1),
      .instr     (instrD),
      .pcplus4   (pcplus4D),
      .valid     (valid_r)
   );

   assign imem_addr = pcF;
   assign validD    = valid_r && in_run;
   assign opD       = instrD[OP_MSB:OP_LSB];
   assign functD    = instrD[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else if (ifid_en) begin
         if (ifid_clr)
            flush_cnt <= flush_cnt + 32'd1;
         else
            fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule
